// File: rtl/io_output_drain.sv
`default_nettype none
// ============================================================================
// Module   : io_output_drain
// Purpose  : Captures the CPU write-back IO word stream (ioValid strobe plus
//            ioData bus) into a small FIFO so the CPU never stalls on IO. Each
//            word is zero-extended to 32 bits and sent MSB first as four bytes
//            on a valid/ready byte port that feeds the UART/display sink.
// Ports    : clock      - system clock, rising edge
//            reset      - asynchronous, active-low reset
//            ioValid    - one word per high cycle
//            ioData     - CPU IO word, sampled while ioValid=1
//            byteReady  - sink accepts byteData this cycle
//            byteValid  - byteData holds a valid byte
//            byteData   - current byte, 0 whenever byteValid=0
//            fifoCount  - words waiting in the FIFO (excludes the word in the shifter)
//            overflow   - sticky, set when a word was dropped on a full FIFO
//            busy       - serialiser active or FIFO not empty
// Revision : 1.0 - initial release
// ============================================================================
module io_output_drain #(
  parameter int DATAWIDTH = 25,
  parameter int DEPTH     = 8,
  parameter int ADDRW     = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ioValid,
  input  logic [DATAWIDTH-1:0] ioData,
  input  logic                 byteReady,
  output logic                 byteValid,
  output logic [7:0]           byteData,
  output logic [ADDRW:0]       fifoCount,
  output logic                 overflow,
  output logic                 busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [ADDRW:0] c_full = (ADDRW+1)'(DEPTH);

  logic [DATAWIDTH-1:0] r_mem [DEPTH];
  logic [ADDRW-1:0]     r_wr_ptr;
  logic [ADDRW-1:0]     r_rd_ptr;
  logic [ADDRW:0]       r_count;
  logic                 r_overflow;
  state_t               r_state;
  state_t               w_state_next;
  logic [31:0]          r_shreg;
  logic [1:0]           r_byte_idx;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_shift;

  // Fullness is judged on the registered count only: a pop on the same edge
  // does not make room for an incoming word.
  assign w_full  = (r_count == c_full);
  assign w_push  = ioValid && !w_full;
  assign w_pop   = (r_state == IDLE) && (r_count != '0);
  assign w_shift = (r_state == SEND) && byteReady;

  // Storage array carries no reset; validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ioData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (ioValid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (byteReady && (r_byte_idx == 2'd3)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shifter: loaded with the zero-extended head word on a pop, shifted left
  // one byte per accepted byte so the outgoing byte is always the top one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shreg    <= '0;
      r_byte_idx <= '0;
    end else if (w_pop) begin
      r_shreg    <= 32'(r_mem[r_rd_ptr]);
      r_byte_idx <= '0;
    end else if (w_shift) begin
      r_shreg    <= {r_shreg[23:0], 8'h00};
      r_byte_idx <= r_byte_idx + 1'b1;
    end
  end

  assign byteValid = (r_state == SEND);
  assign byteData  = byteValid ? r_shreg[31:24] : 8'h00;
  assign fifoCount = r_count;
  assign overflow  = r_overflow;
  assign busy      = (r_state != IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_io_output_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_output_drain
// Purpose  : Self-checking bench for io_output_drain. A queue-based reference
//            model tracks the words waiting and the bytes still owed for the
//            word being sent; a negedge monitor compares every output against
//            it, and scenario tasks check spec-level expectations directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_output_drain;

  localparam int DW    = 25;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clock;
  logic          reset;
  logic          ioValid;
  logic [DW-1:0] ioData;
  logic          byteReady;
  logic          byteValid;
  logic [7:0]    byteData;
  logic [AW:0]   fifoCount;
  logic          overflow;
  logic          busy;

  int n_total;
  int n_bad;

  io_output_drain #(.DATAWIDTH(DW), .DEPTH(DEPTH), .ADDRW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .ioValid   (ioValid),
    .ioData    (ioData),
    .byteReady (byteReady),
    .byteValid (byteValid),
    .byteData  (byteData),
    .fifoCount (fifoCount),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_q[$];     // words waiting
  logic [7:0]    m_cur[$];   // bytes still owed for the word being sent
  logic          m_ovf;
  logic [31:0]   m_w32;
  logic          m_full;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_cur.delete();
      m_ovf = 1'b0;
    end else begin
      m_full = (m_q.size() == DEPTH);
      if (m_cur.size() != 0) begin
        if (byteReady) void'(m_cur.pop_front());
      end else if (m_q.size() != 0) begin
        m_w32 = 32'(m_q.pop_front());
        for (int k = 0; k < 4; k++) m_cur.push_back(m_w32[31-8*k -: 8]);
      end
      if (ioValid) begin
        if (m_full) m_ovf = 1'b1;
        else        m_q.push_back(ioData);
      end
    end
  end

  // ---------------- monitor ----------------
  logic [7:0] got[$];
  logic [7:0] exp_bytes[$];
  logic       e_v;
  logic [7:0] e_d;
  logic [AW:0] e_cnt;
  logic       e_busy;

  always @(negedge clock) begin
    e_v    = (m_cur.size() != 0);
    e_d    = e_v ? m_cur[0] : 8'h00;
    e_cnt  = (AW+1)'(m_q.size());
    e_busy = e_v || (m_q.size() != 0);
    n_total++;
    if ({byteValid, byteData, fifoCount, overflow, busy} !==
        {e_v, e_d, e_cnt, m_ovf, e_busy}) begin
      n_bad++;
      $display("FAIL monitor t=%0t got v=%b d=%h cnt=%0d ovf=%b busy=%b want v=%b d=%h cnt=%0d ovf=%b busy=%b",
               $time, byteValid, byteData, fifoCount, overflow, busy,
               e_v, e_d, e_cnt, m_ovf, e_busy);
    end
    if (byteValid === 1'b1 && byteReady === 1'b1) got.push_back(byteData);
  end

  function automatic void add_word(input logic [DW-1:0] w);
    logic [31:0] x;
    x = 32'(w);
    for (int k = 0; k < 4; k++) exp_bytes.push_back(x[31-8*k -: 8]);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!busy && !byteValid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_total++;
    if ({byteValid, byteData, fifoCount, overflow, busy} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%b d=%h cnt=%0d ovf=%b busy=%b want all 0",
               byteValid, byteData, fifoCount, overflow, busy);
    end
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
    n_total++;
    if (byteValid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release got v=%b busy=%b want 0 0", byteValid, busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    got.delete(); exp_bytes.delete();
    add_word(25'h1ABCDEF);
    ioValid = 1'b1; ioData = 25'h1ABCDEF; byteReady = 1'b1;
    step();
    ioValid = 1'b0;
    n_total++;
    if (fifoCount !== 4'd1 || byteValid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_push got cnt=%0d v=%b want 1 0", fifoCount, byteValid);
    end
    step();
    n_total++;
    if (byteValid !== 1'b1 || byteData !== 8'h01 || fifoCount !== 4'd0) begin
      n_bad++;
      $display("FAIL single_first got v=%b d=%h cnt=%0d want 1 01 0", byteValid, byteData, fifoCount);
    end
    drain(ok);
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL single_drain timeout got busy=%b want 0", busy); end
    ok = (got.size() == exp_bytes.size());
    foreach (exp_bytes[i]) if (ok && got[i] !== exp_bytes[i]) ok = 1'b0;
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL single_bytes got %0d bytes want %0d (01 AB CD EF)", got.size(), exp_bytes.size());
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w;
    logic pv, pr;
    logic [7:0] pd;
    bit ok;
    got.delete(); exp_bytes.delete();
    w = DW'($urandom);
    add_word(w);
    ioValid = 1'b1; ioData = w; byteReady = 1'b0;
    step();
    ioValid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      byteReady = c[0];
      pv = byteValid; pd = byteData; pr = byteReady;
      step();
      if (pv && !pr) begin
        n_total++;
        if (byteValid !== 1'b1 || byteData !== pd) begin
          n_bad++;
          $display("FAIL bp_hold got v=%b d=%h want 1 %h", byteValid, byteData, pd);
        end
      end
    end
    byteReady = 1'b1;
    drain(ok);
    ok = ok && (got.size() == exp_bytes.size());
    foreach (exp_bytes[i]) if (ok && got[i] !== exp_bytes[i]) ok = 1'b0;
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL bp_bytes got %0d bytes want %0d", got.size(), exp_bytes.size());
    end
  endtask

  task automatic test_simul();
    logic [DW-1:0] a, b;
    bit ok;
    got.delete(); exp_bytes.delete();
    a = DW'($urandom); b = DW'($urandom);
    add_word(a); add_word(b);
    byteReady = 1'b0;
    ioValid = 1'b1; ioData = a;
    step();
    ioData = b;
    step();
    ioValid = 1'b0;
    n_total++;
    if (fifoCount !== 4'd1 || byteValid !== 1'b1) begin
      n_bad++;
      $display("FAIL simul_count got cnt=%0d v=%b want 1 1", fifoCount, byteValid);
    end
    byteReady = 1'b1;
    drain(ok);
    ok = ok && (got.size() == exp_bytes.size());
    foreach (exp_bytes[i]) if (ok && got[i] !== exp_bytes[i]) ok = 1'b0;
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL simul_order got %0d bytes want %0d", got.size(), exp_bytes.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    got.delete(); exp_bytes.delete();
    byteReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ioValid = 1'b1; ioData = DW'(32'h100000 + i);
      add_word(DW'(32'h100000 + i));
      step();
      ioValid = 1'b0;
      step(); step();
    end
    drain(ok);
    ok = ok && (got.size() == exp_bytes.size());
    foreach (exp_bytes[i]) if (ok && got[i] !== exp_bytes[i]) ok = 1'b0;
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wrap_stream got %0d bytes want %0d", got.size(), exp_bytes.size());
    end
    n_total++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_overflow got %b want 0", overflow);
    end
  endtask

  task automatic test_burst();
    int exp_cnt;
    bit ok;
    got.delete(); exp_bytes.delete();
    byteReady = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      ioValid = 1'b1; ioData = DW'(i);
      if (i <= 9) add_word(DW'(i));
      step();
      exp_cnt = (i == 1) ? 1 : ((i == 10) ? 8 : i - 1);
      n_total++;
      if (fifoCount !== (AW+1)'(exp_cnt) || overflow !== (i == 10)) begin
        n_bad++;
        $display("FAIL burst_push%0d got cnt=%0d ovf=%b want %0d %b",
                 i, fifoCount, overflow, exp_cnt, (i == 10));
      end
    end
    ioValid = 1'b0;
    byteReady = 1'b1;
    drain(ok);
    ok = ok && (got.size() == exp_bytes.size());
    foreach (exp_bytes[i]) if (ok && got[i] !== exp_bytes[i]) ok = 1'b0;
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL burst_bytes got %0d bytes want %0d", got.size(), exp_bytes.size());
    end
    n_total++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL burst_sticky got %b want 1", overflow);
    end
  endtask

  task automatic test_reset_mid();
    ioValid = 1'b1; ioData = DW'($urandom); byteReady = 1'b1;
    step();
    ioValid = 1'b1; ioData = DW'($urandom);
    step();
    ioValid = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({byteValid, byteData, fifoCount, overflow, busy} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_mid got v=%b d=%h cnt=%0d ovf=%b busy=%b want all 0",
               byteValid, byteData, fifoCount, overflow, busy);
    end
    step();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_total++;
      if (byteValid !== 1'b0 || fifoCount !== 4'd0) begin
        n_bad++;
        $display("FAIL reset_mid_idle got v=%b cnt=%0d want 0 0", byteValid, fifoCount);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    got.delete();
    for (int c = 0; c < 400; c++) begin
      ioValid   = ($urandom_range(0, 2) == 0);
      ioData    = DW'($urandom);
      byteReady = ($urandom_range(0, 3) != 0);
      step();
    end
    ioValid = 1'b0;
    byteReady = 1'b1;
    drain(ok);
    n_total++;
    if (!ok || (got.size() % 4) != 0) begin
      n_bad++;
      $display("FAIL random_drain got ok=%b bytes=%0d want ok=1 bytes multiple of 4", ok, got.size());
    end
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    reset = 1'b1; ioValid = 1'b0; ioData = '0; byteReady = 1'b0;
    #2 reset = 1'b0;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_simul();
    test_wrap();
    test_burst();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
